gpu_ram_host_port: RTL and testbench



---
 rtl/gpu_host_pkg.sv | 32 +++
 rtl/gpu_cmd_fifo.sv | 51 +++++
 rtl/gpu_ram_host_port.sv | 142 ++++++++++++++
 tb/tb_gpu_ram_host_port.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_host_pkg.sv
// Shared types and constants for the GPU-RAM host port: command record, read-pipe tag,
// issue FSM states and the value returned for reads outside the implemented RAM.
package gpu_host_pkg;

    localparam int unsigned ADDR_BITS_DFLT     = 20;
    localparam int unsigned MEM_SIZE_BITS_DFLT = 15;
    // Commands carry a fixed-width address so the FIFO type is independent of ADDR_BITS.
    localparam int unsigned CMD_ADDR_BITS      = 32;
    localparam logic [7:0]  OOR_RDATA          = 8'hFF;

    typedef struct packed {
        logic                     we;
        logic [CMD_ADDR_BITS-1:0] addr;
        logic [7:0]               wdata;
    } cmd_t;

    typedef struct packed {
        logic valid;
        logic force_ff;
    } rd_tag_t;

    typedef enum logic {
        StIdle,
        StIssue
    } issue_state_e;

    function automatic logic addr_in_range(input logic [CMD_ADDR_BITS-1:0] addr,
                                           input int unsigned             mem_bits);
        return (addr >> mem_bits) == '0;
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Two-entry registered command FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module gpu_cmd_fifo
    import gpu_host_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  cmd_t push_data_i,
    input  logic pop_i,
    output cmd_t head_o,
    output logic full_o,
    output logic empty_o
);

    cmd_t       mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok, pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gpu_ram_host_port.sv
// GPU-RAM responder for the Z80 bridge: queues host writes/reads, issues them into granted
// RAM slots and returns read data in request order with a one-cycle ready pulse.
module gpu_ram_host_port
    import gpu_host_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = ADDR_BITS_DFLT,
    parameter int unsigned MEM_SIZE_BITS = MEM_SIZE_BITS_DFLT,
    parameter int unsigned READ_LATENCY  = 2
) (
    input  logic                     GPU_CLK,
    input  logic                     resetn,
    input  logic                     host_wr_ena,
    input  logic                     host_rd_req,
    input  logic [ADDR_BITS-1:0]     host_addr,
    input  logic [7:0]               host_wdata,
    output logic [7:0]               host_rData,
    output logic                     host_rd_rdy,
    output logic                     host_overflow,
    input  logic                     ram_slot_next,
    output logic [MEM_SIZE_BITS-1:0] ram_addr,
    output logic                     ram_wena,
    output logic                     ram_rd,
    output logic [7:0]               ram_wdata,
    input  logic [7:0]               ram_rdata
);

    cmd_t         cmd_in, head;
    logic         fifo_full, fifo_empty;
    logic         push_req, push, pop;
    logic         head_in_range;
    issue_state_e state_q, state_d;
    rd_tag_t      pipe_in;
    rd_tag_t      pipe_q [READ_LATENCY+1];

    logic                     overflow_q, overflow_d;
    logic [MEM_SIZE_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]               ram_wdata_q, ram_wdata_d;
    logic                     ram_wena_q, ram_wena_d;
    logic                     ram_rd_q, ram_rd_d;
    logic [7:0]               rdata_q;
    logic                     rdy_q;

    always_comb begin
        cmd_in.we    = host_wr_ena;
        cmd_in.addr  = CMD_ADDR_BITS'(host_addr);
        cmd_in.wdata = host_wdata;
    end

    assign head_in_range = addr_in_range(head.addr, MEM_SIZE_BITS);
    assign push_req      = host_wr_ena ^ host_rd_req;
    assign push          = push_req;

    gpu_cmd_fifo u_fifo (
        .clk_i       (GPU_CLK),
        .rst_ni      (resetn),
        .push_i      (push),
        .push_data_i (cmd_in),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wena_d  = 1'b0;
        ram_rd_d    = 1'b0;
        pipe_in     = '0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Out-of-range heads never touch RAM, so they do not wait for a slot.
                if (!fifo_empty && (!head_in_range || ram_slot_next)) begin
                    pop = 1'b1;
                end
                if (pop && head_in_range) begin
                    ram_addr_d  = head.addr[MEM_SIZE_BITS-1:0];
                    ram_wdata_d = head.wdata;
                    ram_wena_d  = head.we;
                    ram_rd_d    = !head.we;
                end
                pipe_in.valid    = pop && !head.we;
                pipe_in.force_ff = pop && !head.we && !head_in_range;
                // Single entry leaving with nothing arriving: FIFO is about to be empty.
                if (fifo_empty || (pop && !fifo_full && !push)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign overflow_d = overflow_q || (host_wr_ena && host_rd_req)
                        || (push_req && fifo_full && !pop);

    always_ff @(posedge GPU_CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            overflow_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wena_q  <= 1'b0;
            ram_rd_q    <= 1'b0;
            rdata_q     <= '0;
            rdy_q       <= 1'b0;
            for (int i = 0; i <= int'(READ_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wena_q  <= ram_wena_d;
            ram_rd_q    <= ram_rd_d;
            pipe_q[0]   <= pipe_in;
            for (int i = 1; i <= int'(READ_LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            rdy_q <= pipe_q[READ_LATENCY].valid;
            if (pipe_q[READ_LATENCY].valid) begin
                rdata_q <= pipe_q[READ_LATENCY].force_ff ? OOR_RDATA : ram_rdata;
            end
        end
    end

    assign host_rData    = rdata_q;
    assign host_rd_rdy   = rdy_q;
    assign host_overflow = overflow_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_wena      = ram_wena_q;
    assign ram_rd        = ram_rd_q;

endmodule

// File: tb/tb_gpu_ram_host_port.sv
// Directed bench for gpu_ram_host_port with a two-clock-latency RAM model.
module tb_gpu_ram_host_port;

    logic        GPU_CLK = 1'b0;
    logic        resetn;
    logic        host_wr_ena, host_rd_req;
    logic [19:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rData;
    logic        host_rd_rdy, host_overflow;
    logic        ram_slot_next;
    logic [14:0] ram_addr;
    logic        ram_wena, ram_rd;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int errors = 0;
    int checks = 0;

    gpu_ram_host_port #(
        .ADDR_BITS     (20),
        .MEM_SIZE_BITS (15),
        .READ_LATENCY  (2)
    ) dut (
        .GPU_CLK       (GPU_CLK),
        .resetn        (resetn),
        .host_wr_ena   (host_wr_ena),
        .host_rd_req   (host_rd_req),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_rData    (host_rData),
        .host_rd_rdy   (host_rd_rdy),
        .host_overflow (host_overflow),
        .ram_slot_next (ram_slot_next),
        .ram_addr      (ram_addr),
        .ram_wena      (ram_wena),
        .ram_rd        (ram_rd),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 GPU_CLK = ~GPU_CLK;

    function automatic logic [7:0] rmem(input logic [14:0] a);
        case (a)
            15'h0040: return 8'hC3;
            15'h0010: return 8'h11;
            15'h0011: return 8'h22;
            15'h0200: return 8'h77;
            default:  return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // RAM model: data valid two clocks after the cycle ram_rd is presented.
    logic [7:0] rd_stage;
    always @(posedge GPU_CLK) begin
        rd_stage  <= ram_rd ? rmem(ram_addr) : 8'h00;
        ram_rdata <= rd_stage;
    end

    int         rd_cnt = 0, wena_cnt = 0, rdy_cnt = 0;
    logic [7:0] rdy_log [$];
    logic [14:0] wr_log_addr [$];
    logic [7:0]  wr_log_data [$];
    always @(posedge GPU_CLK) begin
        if (ram_rd) rd_cnt <= rd_cnt + 1;
        if (ram_wena) begin
            wena_cnt <= wena_cnt + 1;
            wr_log_addr.push_back(ram_addr);
            wr_log_data.push_back(ram_wdata);
        end
        if (host_rd_rdy) begin
            rdy_cnt <= rdy_cnt + 1;
            rdy_log.push_back(host_rData);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge GPU_CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic we, input logic [19:0] a, input logic [7:0] d);
        host_wr_ena = we;
        host_rd_req = !we;
        host_addr   = a;
        host_wdata  = d;
        tick();
        host_wr_ena = 1'b0;
        host_rd_req = 1'b0;
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        #2 resetn = 1'b1;
    endtask

    int rd0, wena0, rdy0;
    logic [31:0] outs;

    initial begin
        resetn = 1'b0;
        host_wr_ena = 1'b0;
        host_rd_req = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        ram_slot_next = 1'b1;
        #3;
        outs = {host_rData, host_rd_rdy, host_overflow, ram_wena, ram_rd, ram_addr[7:0], ram_wdata};
        check("reset_outputs", outs, 32'h0);
        #4 resetn = 1'b1;
        tick();
        ticks(2);

        // Single write: strobe in cycle 2 only.
        rdy0 = rdy_cnt;
        pulse(1'b1, 20'h00123, 8'h5A);
        tick();
        check("wr_cycle1_wena", {31'd0, ram_wena}, 32'd0);
        tick();
        check("wr_cycle2_wena", {31'd0, ram_wena}, 32'd1);
        check("wr_addr", {17'd0, ram_addr}, 32'h0123);
        check("wr_data", {24'd0, ram_wdata}, 32'h5A);
        tick();
        check("wr_cycle3_wena", {31'd0, ram_wena}, 32'd0);
        ticks(4);
        check("wr_no_rdy", rdy_cnt, rdy0);

        // Single read: ram_rd in cycle 2, ready in cycle 5.
        pulse(1'b0, 20'h00040, 8'h00);
        tick();
        tick();
        check("rd_cycle2_rd", {31'd0, ram_rd}, 32'd1);
        check("rd_addr", {17'd0, ram_addr}, 32'h0040);
        ticks(2);
        check("rd_cycle4_rdy", {31'd0, host_rd_rdy}, 32'd0);
        tick();
        check("rd_cycle5_rdy", {31'd0, host_rd_rdy}, 32'd1);
        check("rd_data", {24'd0, host_rData}, 32'hC3);
        tick();
        check("rd_cycle6_rdy", {31'd0, host_rd_rdy}, 32'd0);
        check("rd_data_held", {24'd0, host_rData}, 32'hC3);
        ticks(3);

        // Stall: no slot for 10 cycles.
        ram_slot_next = 1'b0;
        rd0 = rd_cnt;
        pulse(1'b0, 20'h00200, 8'h00);
        ticks(10);
        check("stall_no_rd", rd_cnt, rd0);
        ram_slot_next = 1'b1;
        tick();
        check("stall_rd_after_slot", {31'd0, ram_rd}, 32'd1);
        ticks(2);
        check("stall_rdy_early", {31'd0, host_rd_rdy}, 32'd0);
        tick();
        check("stall_rdy", {31'd0, host_rd_rdy}, 32'd1);
        check("stall_data", {24'd0, host_rData}, 32'h77);
        ticks(3);

        // In-order responses including an out-of-range read.
        rd0 = rd_cnt;
        rdy0 = rdy_cnt;
        rdy_log.delete();
        pulse(1'b0, 20'h00010, 8'h00);
        pulse(1'b0, 20'h08000, 8'h00);
        pulse(1'b0, 20'h00011, 8'h00);
        ticks(12);
        check("order_rdy_count", rdy_cnt - rdy0, 32'd3);
        check("order_rd_count", rd_cnt - rd0, 32'd2);
        check("order_len", rdy_log.size(), 32'd3);
        if (rdy_log.size() == 3) begin
            check("order_d0", {24'd0, rdy_log[0]}, 32'h11);
            check("order_d1", {24'd0, rdy_log[1]}, 32'hFF);
            check("order_d2", {24'd0, rdy_log[2]}, 32'h22);
        end
        check("order_no_overflow", {31'd0, host_overflow}, 32'd0);

        // Overflow: three writes with no slots.
        ram_slot_next = 1'b0;
        wena0 = wena_cnt;
        wr_log_addr.delete();
        wr_log_data.delete();
        pulse(1'b1, 20'h00300, 8'h01);
        pulse(1'b1, 20'h00301, 8'h02);
        check("ovf_not_yet", {31'd0, host_overflow}, 32'd0);
        pulse(1'b1, 20'h00302, 8'h03);
        check("ovf_set", {31'd0, host_overflow}, 32'd1);
        ram_slot_next = 1'b1;
        ticks(8);
        check("ovf_wena_count", wena_cnt - wena0, 32'd2);
        if (wr_log_addr.size() == 2) begin
            check("ovf_w0", {9'd0, wr_log_addr[0], wr_log_data[0]}, 32'h0003_0001);
            check("ovf_w1", {9'd0, wr_log_addr[1], wr_log_data[1]}, 32'h0003_0102);
        end
        check("ovf_sticky", {31'd0, host_overflow}, 32'd1);

        // Both pulses together: nothing queued.
        do_reset();
        tick();
        check("reset_clears_ovf", {31'd0, host_overflow}, 32'd0);
        rd0 = rd_cnt;
        wena0 = wena_cnt;
        rdy0 = rdy_cnt;
        host_wr_ena = 1'b1;
        host_rd_req = 1'b1;
        host_addr = 20'h00010;
        tick();
        host_wr_ena = 1'b0;
        host_rd_req = 1'b0;
        check("both_ovf", {31'd0, host_overflow}, 32'd1);
        ticks(8);
        check("both_nothing", (rd_cnt - rd0) + (wena_cnt - wena0) + (rdy_cnt - rdy0), 32'd0);

        // Reset while a read is in the pipe.
        pulse(1'b0, 20'h00040, 8'h00);
        ticks(3);
        rdy0 = rdy_cnt;
        #2 resetn = 1'b0;
        #1;
        outs = {host_rData, host_rd_rdy, host_overflow, ram_wena, ram_rd, ram_addr[7:0], ram_wdata};
        check("async_reset_outputs", outs, 32'h0);
        resetn = 1'b1;
        tick();
        ticks(8);
        check("reset_no_rdy", rdy_cnt, rdy0);
        check("reset_ovf_clear", {31'd0, host_overflow}, 32'd0);
        pulse(1'b0, 20'h00010, 8'h00);
        ticks(4);
        check("post_reset_rdy_early", {31'd0, host_rd_rdy}, 32'd0);
        tick();
        check("post_reset_rdy", {31'd0, host_rd_rdy}, 32'd1);
        check("post_reset_data", {24'd0, host_rData}, 32'h11);
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
